// File: rtl/vxe_vpu_prod_eu_fetch_pkg.sv
// Shared VPU constants for the product execution unit operand fetch stage.
package vxe_vpu_prod_eu_fetch_pkg;

    localparam int unsigned WADDR_W = 37;
    localparam int unsigned ELEM_W  = 32;

    localparam logic [1:0] LANE_LO   = 2'b01;
    localparam logic [1:0] LANE_HI   = 2'b10;
    localparam logic [1:0] LANE_BOTH = 2'b11;

endpackage

// File: rtl/vxe_vpu_fifo.sv
// Parameterised synchronous FIFO with occupancy count; caller never pushes when full or pops when empty.
module vxe_vpu_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 wdata,
    input  logic                         pop,
    output logic [W-1:0]                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign count = cnt;

endmodule

// File: rtl/vxe_vpu_prod_eu_fetch.sv
// VPU product EU operand fetch: credit-limited read requests, response buffering, 2-lane unpack.
// Optional error checking enabled by defining VXE_VPU_PROD_EU_FETCH_ERRCHK_EN (adds o_err).
module vxe_vpu_prod_eu_fetch
    import vxe_vpu_prod_eu_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_ag_valid,
    input  logic [WADDR_W-1:0] i_ag_addr,
    input  logic [1:0]         i_ag_we_mask,
    output logic               o_ag_incr,
    output logic               o_rqa_valid,
    output logic [WADDR_W-1:0] o_rqa_addr,
    input  logic               i_rqa_rdy,
    input  logic               i_rss_valid,
    input  logic [DW-1:0]      i_rss_data,
    output logic               o_elem_valid,
    output logic [ELEM_W-1:0]  o_elem,
    input  logic               i_elem_rdy,
    output logic               o_busy
`ifdef VXE_VPU_PROD_EU_FETCH_ERRCHK_EN
    ,
    output logic               o_err
`endif
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [CW-1:0] mcnt;
    logic [CW-1:0] dcnt;
    logic [1:0]    hmask;
    logic [DW-1:0] hdata;
    logic          phase;
    logic          hi_sel;
    logic          last_lane;
    logic          skip;
    logic          rss_push;
    logic          pop;
    logic          elem_hs;

    vxe_vpu_fifo #(.DEPTH(DEPTH), .W(2)) u_mask_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (o_ag_incr),
        .wdata (i_ag_we_mask),
        .pop   (pop),
        .rdata (hmask),
        .count (mcnt)
    );

    vxe_vpu_fifo #(.DEPTH(DEPTH), .W(DW)) u_data_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rss_push),
        .wdata (i_rss_data),
        .pop   (pop),
        .rdata (hdata),
        .count (dcnt)
    );

    // Credit, lane selection and pop control.
    always_comb begin
        o_rqa_valid  = i_ag_valid && (mcnt < CW'(DEPTH));
        o_rqa_addr   = i_ag_addr;
        o_ag_incr    = o_rqa_valid && i_rqa_rdy;
        o_busy       = i_ag_valid || (mcnt != '0);
        hi_sel       = phase || !(|(hmask & LANE_LO));
        last_lane    = hi_sel || !(|(hmask & LANE_HI));
        o_elem       = hi_sel ? hdata[DW-1:ELEM_W] : hdata[ELEM_W-1:0];
        skip         = 1'b0;
        o_elem_valid = (dcnt != '0);
        rss_push     = i_rss_valid;
`ifdef VXE_VPU_PROD_EU_FETCH_ERRCHK_EN
        skip         = (dcnt != '0) && (hmask == 2'b00);
        o_elem_valid = (dcnt != '0) && !skip;
        rss_push     = i_rss_valid && (dcnt != mcnt);
`endif
        elem_hs      = o_elem_valid && i_elem_rdy;
        pop          = (elem_hs && last_lane) || skip;
    end

    // Phase returns to the entry's first lane whenever the head entry retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= 1'b0;
        end else if (elem_hs) begin
            phase <= !last_lane;
        end
    end

`ifdef VXE_VPU_PROD_EU_FETCH_ERRCHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_err <= 1'b0;
        end else if ((i_rss_valid && (dcnt == mcnt)) || (o_ag_incr && (i_ag_we_mask == 2'b00))) begin
            o_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vxe_vpu_prod_eu_fetch.sv
// Directed bench for vxe_vpu_prod_eu_fetch: vector table plus credit, back-pressure and reset sequences.
module tb_vxe_vpu_prod_eu_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ag_valid = 1'b0;
    logic [36:0] ag_addr = '0;
    logic [1:0]  ag_mask = 2'b00;
    logic        ag_incr;
    logic        rqa_valid;
    logic [36:0] rqa_addr;
    logic        rqa_rdy = 1'b0;
    logic        rss_valid = 1'b0;
    logic [63:0] rss_data = '0;
    logic        elem_valid;
    logic [31:0] elem;
    logic        elem_rdy = 1'b0;
    logic        busy;
`ifdef VXE_VPU_PROD_EU_FETCH_ERRCHK_EN
    logic        err;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    vxe_vpu_prod_eu_fetch #(.DEPTH(4), .DW(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_ag_valid   (ag_valid),
        .i_ag_addr    (ag_addr),
        .i_ag_we_mask (ag_mask),
        .o_ag_incr    (ag_incr),
        .o_rqa_valid  (rqa_valid),
        .o_rqa_addr   (rqa_addr),
        .i_rqa_rdy    (rqa_rdy),
        .i_rss_valid  (rss_valid),
        .i_rss_data   (rss_data),
        .o_elem_valid (elem_valid),
        .o_elem       (elem),
        .i_elem_rdy   (elem_rdy),
        .o_busy       (busy)
`ifdef VXE_VPU_PROD_EU_FETCH_ERRCHK_EN
        ,
        .o_err        (err)
`endif
    );

    typedef struct {
        logic        agv;
        logic [36:0] addr;
        logic [1:0]  mask;
        logic        rdy;
        logic        rv;
        logic [63:0] data;
        logic        er;
        logic        e_rv;
        logic        e_incr;
        logic        e_ev;
        logic [31:0] e_elem;
        logic        e_busy;
    } vec_t;

    vec_t tv [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Drive one cycle's inputs at the falling edge; outputs settle 1 time unit later.
    task automatic drive(input logic agv, input logic [36:0] a, input logic [1:0] m, input logic rdy,
                         input logic rv, input logic [63:0] d, input logic er);
        @(negedge clk);
        ag_valid  = agv;
        ag_addr   = a;
        ag_mask   = m;
        rqa_rdy   = rdy;
        rss_valid = rv;
        rss_data  = d;
        elem_rdy  = er;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ag_valid = 1'b0; rqa_rdy = 1'b0; rss_valid = 1'b0; elem_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n_incr;
        int n_elem;
        logic [31:0] got [2];

        tv[0]  = '{1'b1, 37'h08, 2'b11, 1'b1, 1'b0, 64'h0,                 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1};
        tv[1]  = '{1'b1, 37'h09, 2'b01, 1'b1, 1'b0, 64'h0,                 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1};
        tv[2]  = '{1'b0, 37'h00, 2'b00, 1'b1, 1'b1, 64'h2222222211111111,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1};
        tv[3]  = '{1'b0, 37'h00, 2'b00, 1'b1, 1'b1, 64'h4444444433333333,  1'b1, 1'b0, 1'b0, 1'b1, 32'h11111111, 1'b1};
        tv[4]  = '{1'b0, 37'h00, 2'b00, 1'b1, 1'b0, 64'h0,                 1'b1, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b1};
        tv[5]  = '{1'b0, 37'h00, 2'b00, 1'b1, 1'b0, 64'h0,                 1'b1, 1'b0, 1'b0, 1'b1, 32'h33333333, 1'b1};
        tv[6]  = '{1'b0, 37'h00, 2'b00, 1'b1, 1'b0, 64'h0,                 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
        tv[7]  = '{1'b1, 37'h08, 2'b10, 1'b1, 1'b0, 64'h0,                 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1};
        tv[8]  = '{1'b1, 37'h09, 2'b01, 1'b1, 1'b0, 64'h0,                 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1};
        tv[9]  = '{1'b0, 37'h00, 2'b00, 1'b1, 1'b1, 64'hBBBBBBBBAAAAAAAA,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1};
        tv[10] = '{1'b0, 37'h00, 2'b00, 1'b1, 1'b1, 64'hDDDDDDDDCCCCCCCC,  1'b1, 1'b0, 1'b0, 1'b1, 32'hBBBBBBBB, 1'b1};
        tv[11] = '{1'b0, 37'h00, 2'b00, 1'b1, 1'b0, 64'h0,                 1'b1, 1'b0, 1'b0, 1'b1, 32'hCCCCCCCC, 1'b1};
        tv[12] = '{1'b0, 37'h00, 2'b00, 1'b1, 1'b0, 64'h0,                 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0};

        // Reset state
        do_reset();
        drive(1'b0, 37'h0, 2'b00, 1'b0, 1'b0, 64'h0, 1'b0);
        chk("rst_rqa_valid",  64'(rqa_valid),  64'h0);
        chk("rst_ag_incr",    64'(ag_incr),    64'h0);
        chk("rst_elem_valid", 64'(elem_valid), 64'h0);
        chk("rst_busy",       64'(busy),       64'h0);
`ifdef VXE_VPU_PROD_EU_FETCH_ERRCHK_EN
        chk("rst_err",        64'(err),        64'h0);
`endif

        // Aligned odd length, then unaligned start with simultaneous push/pop
        for (int i = 0; i < 13; i++) begin
            drive(tv[i].agv, tv[i].addr, tv[i].mask, tv[i].rdy, tv[i].rv, tv[i].data, tv[i].er);
            chk($sformatf("v%0d_rqa_valid", i),  64'(rqa_valid),  64'(tv[i].e_rv));
            chk($sformatf("v%0d_ag_incr", i),    64'(ag_incr),    64'(tv[i].e_incr));
            chk($sformatf("v%0d_elem_valid", i), 64'(elem_valid), 64'(tv[i].e_ev));
            chk($sformatf("v%0d_busy", i),       64'(busy),       64'(tv[i].e_busy));
            if (tv[i].e_rv) chk($sformatf("v%0d_rqa_addr", i), 64'(rqa_addr), 64'(tv[i].addr));
            if (tv[i].e_ev) chk($sformatf("v%0d_elem", i),     64'(elem),     64'(tv[i].e_elem));
        end

        // Request back-pressure holds the request and address
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 37'h1ABCDEF01, 2'b11, 1'b0, 1'b0, 64'h0, 1'b1);
            chk("bp_rqa_valid", 64'(rqa_valid), 64'h1);
            chk("bp_ag_incr",   64'(ag_incr),   64'h0);
            chk("bp_rqa_addr",  64'(rqa_addr),  64'h1ABCDEF01);
        end

        // Credit limit: four requests, then stall
        n_incr = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 37'h1ABCDEF01, 2'b11, 1'b1, 1'b0, 64'h0, 1'b1);
            if (ag_incr) n_incr++;
        end
        chk("credit_incr_count", 64'(n_incr),    64'd4);
        chk("credit_rqa_valid",  64'(rqa_valid), 64'h0);

        // One response frees exactly one credit once both lanes are consumed
        drive(1'b1, 37'h1ABCDEF01, 2'b11, 1'b1, 1'b1, 64'h8888888877777777, 1'b1);
        chk("credit_rsp_rqa_valid", 64'(rqa_valid), 64'h0);
        n_incr = 0;
        n_elem = 0;
        got[0] = '0;
        got[1] = '0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 37'h1ABCDEF01, 2'b11, 1'b1, 1'b0, 64'h0, 1'b1);
            if (ag_incr) n_incr++;
            if (elem_valid) begin
                if (n_elem < 2) got[n_elem] = elem;
                n_elem++;
            end
        end
        chk("refill_incr_count", 64'(n_incr), 64'd1);
        chk("refill_elem_count", 64'(n_elem), 64'd2);
        chk("refill_elem0",      64'(got[0]), 64'h77777777);
        chk("refill_elem1",      64'(got[1]), 64'h88888888);

        // Element back-pressure: two outstanding, one buffered, consumer stalled
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 37'(20 + i), 2'b11, 1'b1, 1'b0, 64'h0, 1'b0);
        drive(1'b0, 37'h0, 2'b00, 1'b1, 1'b1, 64'h9999999955555555, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 37'h0, 2'b00, 1'b1, 1'b0, 64'h0, 1'b0);
            chk("stall_elem_valid", 64'(elem_valid), 64'h1);
            chk("stall_elem",       64'(elem),       64'h55555555);
            chk("stall_busy",       64'(busy),       64'h1);
        end

        // Reset mid-operation; a response during reset is dropped
        @(negedge clk);
        rst = 1'b1;
        ag_valid = 1'b1; rqa_rdy = 1'b0; rss_valid = 1'b1; rss_data = 64'hEEEEEEEEFFFFFFFF; elem_rdy = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rss_valid = 1'b0;
        #1;
        chk("midrst_elem_valid", 64'(elem_valid), 64'h0);
        chk("midrst_busy",       64'(busy),       64'h1);
        chk("midrst_rqa_valid",  64'(rqa_valid),  64'h1);
        n_incr = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 37'h40, 2'b11, 1'b1, 1'b0, 64'h0, 1'b1);
            if (ag_incr) n_incr++;
            chk("midrst_no_elem", 64'(elem_valid), 64'h0);
        end
        chk("midrst_full_credit", 64'(n_incr), 64'd4);

`ifdef VXE_VPU_PROD_EU_FETCH_ERRCHK_EN
        // Response with nothing outstanding flags an error and is dropped
        do_reset();
        drive(1'b0, 37'h0, 2'b00, 1'b0, 1'b0, 64'h0, 1'b1);
        chk("err_clear", 64'(err), 64'h0);
        drive(1'b0, 37'h0, 2'b00, 1'b0, 1'b1, 64'h1234567812345678, 1'b1);
        drive(1'b0, 37'h0, 2'b00, 1'b0, 1'b0, 64'h0, 1'b1);
        chk("err_set",        64'(err),        64'h1);
        chk("err_elem_valid", 64'(elem_valid), 64'h0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
